// File: rtl/dmem_ctrl_pkg.sv
// rtl/dmem_ctrl_pkg.sv - shared encodings for the data-memory access controller
package dmem_ctrl_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_RANGE    = 2'b10;
  localparam logic [1:0] FC_TIMEOUT  = 2'b11;

endpackage

// File: rtl/dmem_byte_lane.sv
// rtl/dmem_byte_lane.sv - load lane extraction/extension and sub-word store merge
module dmem_byte_lane
  import dmem_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = word[{offset, 3'b000} +: 8];
    half_sel  = offset[1] ? word[31:16] : word[15:0];
    load_data = word;
    case (funct3)
      F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  load_data = {24'h0, byte_sel};
      F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  load_data = {16'h0, half_sel};
      default: load_data = word;
    endcase
  end

  // Stores share funct3[1:0] with loads: 00 byte, 01 half, 10 word.
  always_comb begin
    merged = word;
    case (funct3[1:0])
      2'b00:   merged[{offset, 3'b000} +: 8] = store_data[7:0];
      2'b01:   merged[{offset[1], 4'b0000} +: 16] = store_data[15:0];
      default: merged = store_data;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - sequences RV32 byte/half/word loads and stores onto a word-only memory
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned MEM_BYTES      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  read,
  input  logic [2:0]  write,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        busywait,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [15:0] TMO      = 16'(TIMEOUT_CYCLES);
  localparam logic [31:0] MEM_SIZE = 32'(MEM_BYTES);

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic        load_q, load_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  fc_q, fc_d;
  logic [15:0] cnt_q, cnt_d;

  logic        req_in;
  logic [2:0]  op_f3;
  logic        illegal, misalign, out_of_range, timed_out;
  logic [31:0] lane_load, lane_merged;

  assign req_in = read[3] | write[2];
  assign op_f3  = read[3] ? read[2:0] : {1'b0, write[1:0]};

  always_comb begin
    illegal = (read[3] & write[2])
            | (read[3] & (read[2:0] == 3'b011 || read[2:0] == 3'b110 || read[2:0] == 3'b111))
            | (write[2] & (write[1:0] == 2'b11));
    misalign = ((op_f3[1:0] == 2'b01) & address[0])
             | ((op_f3[1:0] == 2'b10) & (address[1:0] != 2'b00));
    out_of_range = (address >= MEM_SIZE);
    timed_out = (TMO != 16'd0) && (16'(cnt_q + 16'd1) == TMO);
  end

  dmem_byte_lane u_lane (
    .funct3     (f3_q),
    .offset     (off_q),
    .word       (mem_rdata),
    .store_data (writedata),
    .load_data  (lane_load),
    .merged     (lane_merged)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    off_d   = off_q;
    f3_d    = f3_q;
    load_d  = load_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    fc_d    = fc_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_in) begin
          state_d = ST_RESP;
          if (illegal || misalign || out_of_range) begin
            fc_d = illegal ? FC_RANGE : (misalign ? FC_MISALIGN : FC_RANGE);
            if (read[3]) rdata_d = 32'h0;
          end else begin
            fc_d   = FC_NONE;
            addr_d = {address[31:2], 2'b00};
            off_d  = address[1:0];
            f3_d   = op_f3;
            load_d = read[3];
            cnt_d  = 16'd0;
            if (!read[3] && op_f3 == F3_SW) begin
              state_d = ST_WR;
              wdata_d = writedata;
            end else begin
              state_d = ST_RD;
            end
          end
        end
      end
      ST_RD: begin
        if (mem_ack) begin
          cnt_d = 16'd0;
          if (load_q) begin
            state_d = ST_RESP;
            rdata_d = lane_load;
          end else begin
            state_d = ST_WR;
            wdata_d = lane_merged;
          end
        end else if (timed_out) begin
          state_d = ST_RESP;
          fc_d    = FC_TIMEOUT;
          rdata_d = 32'h0;
          cnt_d   = TMO;
        end else begin
          cnt_d = 16'(cnt_q + 16'd1);
        end
      end
      ST_WR: begin
        if (mem_ack) begin
          state_d = ST_RESP;
        end else if (timed_out) begin
          state_d = ST_RESP;
          fc_d    = FC_TIMEOUT;
          rdata_d = 32'h0;
          cnt_d   = TMO;
        end else begin
          cnt_d = 16'(cnt_q + 16'd1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= 32'h0;
      off_q   <= 2'b00;
      f3_q    <= 3'b000;
      load_q  <= 1'b0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      fc_q    <= FC_NONE;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      load_q  <= load_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      fc_q    <= fc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gated by reset so the stall releases in the same cycle reset asserts.
  always_comb begin
    mem_req  = reset & ((state_q == ST_RD) | (state_q == ST_WR));
    mem_we   = reset & (state_q == ST_WR);
    busywait = 1'b0;
    if (reset) begin
      case (state_q)
        ST_IDLE: busywait = req_in;
        ST_RD:   busywait = 1'b1;
        ST_WR:   busywait = 1'b1;
        default: busywait = 1'b0;
      endcase
    end
  end

  assign fault      = (state_q == ST_RESP) && (fc_q != FC_NONE);
  assign fault_code = fc_q;
  assign readdata   = rdata_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - scoreboard bench for dmem_access_ctrl with a word memory model
module tb_dmem_access_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  read = 4'h0;
  logic [2:0]  write = 3'h0;
  logic [31:0] address = 32'h0;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic        busywait, fault;
  logic [1:0]  fault_code;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int passed = 0;
  int total  = 0;

  logic [31:0] mem [0:63];
  int          ack_mode = 0;
  int          wr_count = 0;
  logic        ld_en = 1'b0;
  logic [5:0]  ld_idx = 6'd0;
  logic [31:0] ld_val = 32'h0;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  fc;
    logic        flt;
    int          busy;
    int          reqs;
    int          writes;
  } exp_t;
  exp_t sb_q[$];

  int          o_busy, o_reqs, o_writes;
  logic [31:0] o_rdata, o_addr;
  logic [1:0]  o_fc;
  logic        o_fault;

  always #5 clock = ~clock;

  assign mem_ack   = mem_req && (ack_mode == 0 || (ack_mode == 2 && !mem_we));
  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clock) begin
    if (ld_en) mem[ld_idx] <= ld_val;
    else if (mem_req && mem_we && mem_ack) begin
      mem[mem_addr[7:2]] <= mem_wdata;
      wr_count <= wr_count + 1;
    end
  end

  dmem_access_ctrl #(.MEM_BYTES(256), .TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata),
    .busywait(busywait), .fault(fault), .fault_code(fault_code),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic mem_load(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clock);
    ld_en = 1'b1; ld_idx = idx; ld_val = val;
    @(negedge clock);
    ld_en = 1'b0;
  endtask

  task automatic issue(input logic [3:0] rd, input logic [2:0] wr,
                       input logic [31:0] addr, input logic [31:0] wd);
    int w0;
    bit done;
    @(posedge clock); #1;
    read = rd; write = wr; address = addr; writedata = wd;
    w0 = wr_count; o_busy = 0; o_reqs = 0; o_addr = 32'hx; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clock);
      if (mem_req) begin
        if (o_reqs == 0) o_addr = mem_addr;
        o_reqs++;
      end
      if (busywait) o_busy++;
      else begin
        o_rdata = readdata; o_fc = fault_code; o_fault = fault; done = 1;
      end
    end
    if (!done) o_busy = -1;
    @(posedge clock); #1;
    read = 4'h0; write = 3'h0;
    o_writes = wr_count - w0;
  endtask

  task automatic push(input logic [31:0] r, input logic [1:0] fc, input logic f,
                      input int b, input int q, input int w);
    exp_t e;
    e.rdata = r; e.fc = fc; e.flt = f; e.busy = b; e.reqs = q; e.writes = w;
    sb_q.push_back(e);
  endtask

  task automatic compare(input string name, input bit chk_rdata);
    exp_t e;
    e = sb_q.pop_front();
    total++;
    if (o_busy !== e.busy) $display("FAIL %s busy cycles: got %0d want %0d", name, o_busy, e.busy);
    else if (o_reqs !== e.reqs) $display("FAIL %s mem_req cycles: got %0d want %0d", name, o_reqs, e.reqs);
    else if (o_writes !== e.writes) $display("FAIL %s writes: got %0d want %0d", name, o_writes, e.writes);
    else if (o_fc !== e.fc) $display("FAIL %s fault_code: got %b want %b", name, o_fc, e.fc);
    else if (o_fault !== e.flt) $display("FAIL %s fault: got %b want %b", name, o_fault, e.flt);
    else if (chk_rdata && o_rdata !== e.rdata) $display("FAIL %s readdata: got %h want %h", name, o_rdata, e.rdata);
    else passed++;
  endtask

  task automatic test_reset;
    total++;
    if ({readdata, mem_addr, mem_wdata} !== 96'h0 || {mem_req, mem_we, busywait, fault, fault_code} !== 6'b0)
      $display("FAIL reset_state: got rd=%h ma=%h mw=%h ctl=%b want zeros",
               readdata, mem_addr, mem_wdata, {mem_req, mem_we, busywait, fault, fault_code});
    else passed++;
  endtask

  task automatic test_byte_load;
    push(32'hFFFFFF88, 2'b00, 1'b0, 2, 1, 0);
    issue(4'b1000, 3'b000, 32'h13, 32'h0);
    compare("lb_0x13", 1);
    total++;
    if (o_addr !== 32'h10) $display("FAIL lb_mem_addr: got %h want %h", o_addr, 32'h10);
    else passed++;
    push(32'h00000088, 2'b00, 1'b0, 2, 1, 0);
    issue(4'b1100, 3'b000, 32'h13, 32'h0);
    compare("lbu_0x13", 1);
  endtask

  task automatic test_rmw_store;
    push(32'h0, 2'b00, 1'b0, 3, 2, 1);
    issue(4'b0000, 3'b100, 32'h11, 32'h0000005A);
    compare("sb_0x11", 0);
    total++;
    if (mem[4] !== 32'h88995ABB) $display("FAIL sb_merge: got %h want %h", mem[4], 32'h88995ABB);
    else passed++;
    push(32'h88995ABB, 2'b00, 1'b0, 2, 1, 0);
    issue(4'b1010, 3'b000, 32'h10, 32'h0);
    compare("lw_after_sb", 1);
  endtask

  task automatic test_faults;
    push(32'h0, 2'b01, 1'b1, 1, 0, 0);
    issue(4'b1001, 3'b000, 32'h11, 32'h0);
    compare("lh_misalign", 1);
    push(32'h0, 2'b10, 1'b1, 1, 0, 0);
    issue(4'b1010, 3'b000, 32'h100, 32'h0);
    compare("lw_range", 1);
    push(32'h0, 2'b01, 1'b1, 1, 0, 0);
    issue(4'b0000, 3'b110, 32'h22, 32'hDEAD);
    compare("sw_misalign", 0);
    push(32'h0, 2'b10, 1'b1, 1, 0, 0);
    issue(4'b1011, 3'b000, 32'h0, 32'h0);
    compare("load_f3_011", 1);
  endtask

  task automatic test_timeout;
    ack_mode = 1;
    push(32'h0, 2'b11, 1'b1, 9, 8, 0);
    issue(4'b1010, 3'b000, 32'h20, 32'h0);
    compare("lw_timeout", 1);
    ack_mode = 0;
  endtask

  task automatic test_reset_abort;
    int w0;
    bit seen;
    ack_mode = 2; w0 = wr_count; seen = 0;
    @(posedge clock); #1;
    read = 4'h0; write = 3'b101; address = 32'h12; writedata = 32'h0000BEEF;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock);
      if (mem_req && mem_we) seen = 1;
    end
    reset = 1'b0; #1;
    total++;
    if (!seen || mem_req !== 1'b0 || busywait !== 1'b0)
      $display("FAIL reset_abort: got seen=%b req=%b busy=%b want 1,0,0", seen, mem_req, busywait);
    else passed++;
    write = 3'h0; ack_mode = 0;
    @(negedge clock); reset = 1'b1;
    repeat (4) @(negedge clock);
    total++;
    if (wr_count != w0 || mem_req !== 1'b0 || busywait !== 1'b0 || readdata !== 32'h0 ||
        mem_addr !== 32'h0 || fault_code !== 2'b00 || mem[4] !== 32'h88995ABB)
      $display("FAIL post_reset_idle: got writes=%0d req=%b busy=%b rd=%h ma=%h fc=%b m=%h want %0d,0,0,0,0,00,88995abb",
               wr_count - w0, mem_req, busywait, readdata, mem_addr, fault_code, mem[4], 0);
    else passed++;
  endtask

  task automatic test_illegal_and_lhu;
    push(32'h0, 2'b10, 1'b1, 1, 0, 0);
    issue(4'b1010, 3'b110, 32'h10, 32'h0);
    compare("rd_wr_both", 1);
    push(32'h00008899, 2'b00, 1'b0, 2, 1, 0);
    issue(4'b1101, 3'b000, 32'h12, 32'h0);
    compare("lhu_0x12", 1);
  endtask

  task automatic test_back_to_back;
    logic [31:0] v;
    for (int k = 0; k < 4; k++) begin
      v = $urandom;
      push(32'h0, 2'b00, 1'b0, 2, 1, 1);
      issue(4'b0000, 3'b110, 32'h40 + 32'(k * 4), v);
      compare("sw_b2b", 0);
      push({{16{v[15]}}, v[15:0]}, 2'b00, 1'b0, 2, 1, 0);
      issue(4'b1001, 3'b000, 32'h40 + 32'(k * 4), 32'h0);
      compare("lh_b2b", 1);
    end
    push(32'h0, 2'b00, 1'b0, 3, 2, 1);
    issue(4'b0000, 3'b101, 32'h42, 32'h1234CAFE);
    compare("sh_hi", 0);
    push(32'hFFFFFFCA, 2'b00, 1'b0, 2, 1, 0);
    issue(4'b1000, 3'b000, 32'h43, 32'h0);
    compare("lb_after_sh", 1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    repeat (2) @(negedge clock);
    test_reset;
    reset = 1'b1;
    mem_load(6'd4, 32'h8899AABB);
    test_byte_load;
    test_rmw_store;
    test_faults;
    test_timeout;
    test_reset_abort;
    test_illegal_and_lhu;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
